// File: rtl/apb_pkg.sv
// Shared types and width defaults for the APB request arbiter.
package apb_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/apb_rr_picker.sv
// Rotate-priority encoder: first set request at or after the pointer, wrapping.
module apb_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    localparam logic [PTR_W:0] LIM = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_pos;
    logic             w_hit;

    // Scan requesters in rotated order, keeping only the first hit.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_pos = '0;
        w_hit = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            w_pos = (w_sum >= LIM) ? PTR_W'(w_sum - LIM) : w_sum[PTR_W-1:0];
            w_hit = !o_any && i_req[w_pos];
            o_gnt[w_pos] = o_gnt[w_pos] | w_hit;
            o_idx = w_hit ? w_pos : o_idx;
            o_any = o_any | w_hit;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sharing of one APB master command port among NUM_REQ requesters.
// Optional macro APB_ARB_LOCK_EN adds req_lock to hold the pointer on a granted requester.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef APB_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          transfer,
    output logic                          rd_wr,
    output logic [ADDR_WIDTH-1:0]         write_addr,
    output logic [ADDR_WIDTH-1:0]         read_addr,
    output logic [DATA_WIDTH-1:0]         write_data,
    input  logic                          pselx,
    input  logic                          penable,
    input  logic                          pready,
    input  logic                          pslverr,
    input  logic [DATA_WIDTH-1:0]         prdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t r_state, w_state_nxt;
    logic [PTR_W-1:0]      r_ptr, w_ptr_nxt, r_idx, w_idx_nxt, w_ptr_inc;
    logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt, r_done, w_done_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt, r_wdata, w_wdata_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_nxt, r_raddr, w_raddr_nxt;
    logic                  r_err, w_err_nxt, r_transfer, w_transfer_nxt, r_rd_wr, w_rd_wr_nxt;
    logic [NUM_REQ-1:0]    w_pick_gnt;
    logic [PTR_W-1:0]      w_pick_idx;
    logic                  w_pick_any, w_setup, w_cplt, w_hold_ptr;

    apb_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_setup   = pselx && !penable;
    assign w_cplt    = pselx && penable && pready;
    assign w_ptr_inc = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + PTR_W'(1);
`ifdef APB_ARB_LOCK_EN
    assign w_hold_ptr = req_lock[r_idx];
`else
    assign w_hold_ptr = 1'b0;
`endif

    // State register.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_pick_any ? ISSUE : IDLE;
            ISSUE:   w_state_nxt = w_setup ? WAIT : ISSUE;
            WAIT:    w_state_nxt = w_cplt ? IDLE : WAIT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; done defaults low so it only pulses.
    always_comb begin
        w_ptr_nxt      = r_ptr;
        w_idx_nxt      = r_idx;
        w_gnt_nxt      = r_gnt;
        w_done_nxt     = '0;
        w_rdata_nxt    = r_rdata;
        w_err_nxt      = r_err;
        w_transfer_nxt = r_transfer;
        w_rd_wr_nxt    = r_rd_wr;
        w_waddr_nxt    = r_waddr;
        w_raddr_nxt    = r_raddr;
        w_wdata_nxt    = r_wdata;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_gnt_nxt      = w_pick_gnt;
                    w_idx_nxt      = w_pick_idx;
                    w_rd_wr_nxt    = req_write[w_pick_idx];
                    w_waddr_nxt    = req_addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    w_raddr_nxt    = req_addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    w_wdata_nxt    = req_write[w_pick_idx] ?
                                     req_wdata[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
                    w_transfer_nxt = 1'b1;
                end else begin
                    w_transfer_nxt = r_transfer;
                end
            end
            ISSUE: begin
                // Drop transfer before the master's ACCESS cycle so it returns to IDLE.
                if (w_setup) begin
                    w_transfer_nxt = 1'b0;
                end else begin
                    w_transfer_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (w_cplt) begin
                    w_rdata_nxt = r_rd_wr ? '0 : prdata;
                    w_err_nxt   = pslverr;
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_hold_ptr ? r_idx : w_ptr_inc;
                end else begin
                    w_gnt_nxt   = r_gnt;
                end
            end
            default: begin
                w_gnt_nxt      = '0;
                w_transfer_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_ptr      <= '0;
            r_idx      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_transfer <= 1'b0;
            r_rd_wr    <= 1'b0;
            r_waddr    <= '0;
            r_raddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_idx      <= w_idx_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_rdata    <= w_rdata_nxt;
            r_err      <= w_err_nxt;
            r_transfer <= w_transfer_nxt;
            r_rd_wr    <= w_rd_wr_nxt;
            r_waddr    <= w_waddr_nxt;
            r_raddr    <= w_raddr_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_err;
    assign transfer   = r_transfer;
    assign rd_wr      = r_rd_wr;
    assign write_addr = r_waddr;
    assign read_addr  = r_raddr;
    assign write_data = r_wdata;

endmodule
